// File: rtl/multi_hot_encoder.sv
// Serialises a captured multi-hot vector into one index beat per set bit over a valid/ready stream.
// Optional build macro MULTI_HOT_ENCODER_MSB_FIRST_EN scans from the highest set bit downward.
module multi_hot_encoder #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_vec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] out_idx,
    output logic                     out_last,
    output logic                     out_none
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mask;

`ifdef MULTI_HOT_ENCODER_MSB_FIRST_EN
    // Ascending scan keeps the last hit, i.e. the highest set bit.
    function automatic logic [IDX_W-1:0] pick_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction
`else
    // Descending scan keeps the last hit, i.e. the lowest set bit.
    function automatic logic [IDX_W-1:0] pick_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction
`endif

    function automatic logic [WIDTH-1:0] clear_bit(input logic [WIDTH-1:0] v,
                                                   input logic [IDX_W-1:0] idx);
        logic [WIDTH-1:0] r;
        r = v;
        for (int i = 0; i < WIDTH; i++) begin
            if (IDX_W'(i) == idx) r[i] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic at_most_one(input logic [WIDTH-1:0] v);
        return (v & (v - WIDTH'(1))) == '0;
    endfunction

    function automatic logic exactly_one(input logic [WIDTH-1:0] v);
        return (v != '0) && at_most_one(v);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_none  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mask      <= clear_bit(in_vec, pick_idx(in_vec));
                        out_idx   <= pick_idx(in_vec);
                        out_last  <= at_most_one(in_vec);
                        out_none  <= (in_vec == '0);
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    // Outputs and mask only move on a handshake, so backpressure holds them.
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_none  <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            out_idx  <= pick_idx(mask);
                            mask     <= clear_bit(mask, pick_idx(mask));
                            out_last <= exactly_one(mask);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
